// File: rtl/serial_cmd_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmd_scheduler_pkg
// Shared definitions for the serial command scheduler: command opcode,
// control-byte bit positions, packet byte layout, the queued command record
// and the two FSM state encodings.
// -----------------------------------------------------------------------------
package serial_cmd_scheduler_pkg;

    localparam int CMD_DATA_BIT = 32;
    localparam int PKG_PACK_NUM = 11;

    localparam logic [1:0] CTRL_OPCODE = 2'b01;

    // Control byte layout: [7:4] channel, [3] reserved, [2] mode, [1:0] opcode
    localparam int CTRL_CH_MSB   = 7;
    localparam int CTRL_CH_LSB   = 4;
    localparam int CTRL_RSV_BIT  = 3;
    localparam int CTRL_MODE_BIT = 2;
    localparam int CTRL_OP_MSB   = 1;
    localparam int CTRL_OP_LSB   = 0;

    // Byte positions inside a packet (0-3 out pattern, 4-7 freq pattern)
    localparam int BYTE_CTRL = 8;
    localparam int BYTE_SLOW = 9;
    localparam int BYTE_FAST = 10;

    typedef struct packed {
        logic [3:0]              channel;
        logic                    mode;
        logic [CMD_DATA_BIT-1:0] out_pattern;
        logic [CMD_DATA_BIT-1:0] freq_pattern;
        logic [7:0]              slow_period;
        logic [7:0]              fast_period;
    } cmd_t;

    typedef enum logic [1:0] {
        ASM_IDLE  = 2'd0,
        ASM_RECV  = 2'd1,
        ASM_CHECK = 2'd2
    } asm_state_e;

    typedef enum logic {
        DSP_IDLE  = 1'b0,
        DSP_ISSUE = 1'b1
    } dsp_state_e;

    // A packet is usable only with a clear reserved bit, the known opcode
    // and non-zero bit periods.
    function automatic logic pkt_is_valid(input logic [7:0] ctrl,
                                          input logic [7:0] slow,
                                          input logic [7:0] fast);
        return (ctrl[CTRL_RSV_BIT] == 1'b0) &&
               (ctrl[CTRL_OP_MSB:CTRL_OP_LSB] == CTRL_OPCODE) &&
               (slow != 8'd0) && (fast != 8'd0);
    endfunction

endpackage

// File: rtl/serial_cmd_scheduler_if.sv
// -----------------------------------------------------------------------------
// serial_cmd_scheduler_if
// Command handshake bus between the scheduler (master) and the serial-out
// engine (slave).
//   o_cmd_valid    command presented          i_cmd_ready  engine accepts it
//   o_channel      target channel (4 bits)    o_mode       0 one-shot, 1 repeat
//   o_out_pattern / o_freq_pattern            pattern words (DATA_BIT each)
//   o_slow_period / o_fast_period             bit periods in clocks
// -----------------------------------------------------------------------------
interface serial_cmd_scheduler_if
    import serial_cmd_scheduler_pkg::*;
#(
    parameter int DATA_BIT = CMD_DATA_BIT
) ();
    logic                o_cmd_valid;
    logic                i_cmd_ready;
    logic [3:0]          o_channel;
    logic                o_mode;
    logic [DATA_BIT-1:0] o_out_pattern;
    logic [DATA_BIT-1:0] o_freq_pattern;
    logic [7:0]          o_slow_period;
    logic [7:0]          o_fast_period;

    modport master (
        output o_cmd_valid, o_channel, o_mode, o_out_pattern, o_freq_pattern,
               o_slow_period, o_fast_period,
        input  i_cmd_ready
    );

    modport slave (
        input  o_cmd_valid, o_channel, o_mode, o_out_pattern, o_freq_pattern,
               o_slow_period, o_fast_period,
        output i_cmd_ready
    );
endinterface

// File: rtl/serial_cmd_scheduler_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous first-word-fall-through queue for assembled commands.
//   clk, rst_n      clock; asynchronous active-high reset of the pointers
//   i_wr_en/data    push (accepted when not full, or full with a pop)
//   i_rd_en         pop of the head
//   o_rd_data       current head, valid whenever o_empty is low
//   o_full/o_empty/o_count  occupancy
// -----------------------------------------------------------------------------
module cmd_fifo
    import serial_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok, rd_ok;

    assign o_count   = wr_ptr_q - rd_ptr_q;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_empty   = (o_count == '0);
    assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        rd_ok    = i_rd_en && !o_empty;
        // When full, the slot being freed by a same-cycle pop takes the write.
        wr_ok    = i_wr_en && (!o_full || rd_ok);
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_ok);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end
endmodule

// File: rtl/serial_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// serial_cmd_scheduler
// Assembles PACK_NUM-byte UART packets into commands, validates them, queues
// them, and dispatches them strictly in order to the serial-out engine once
// the target channel is idle.
//   clk, rst_n        clock; asynchronous active-high reset
//   i_data            received UART byte, qualified by i_rx_done_tick
//   i_ch_busy         per-channel busy flags from the engine
//   cmd               command handshake bus (master side)
//   o_err_tick        malformed packet or inter-byte timeout
//   o_overflow_tick   valid packet dropped because the queue was full
//   o_fifo_count      occupied queue entries
// -----------------------------------------------------------------------------
module serial_cmd_scheduler
    import serial_cmd_scheduler_pkg::*;
#(
    parameter int DATA_BIT    = CMD_DATA_BIT,
    parameter int PACK_NUM    = PKG_PACK_NUM,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CLK = 2000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_data,
    input  logic                          i_rx_done_tick,
    input  logic [15:0]                   i_ch_busy,
    serial_cmd_scheduler_if.master        cmd,
    output logic                          o_err_tick,
    output logic                          o_overflow_tick,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int CNT_W = $clog2(PACK_NUM);
    localparam int TMO_W = $clog2(TIMEOUT_CLK);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACK_NUM - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLK - 1);

    asm_state_e          asm_q, asm_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [7:0]          buf_q [PACK_NUM];
    logic [7:0]          buf_d [PACK_NUM];
    dsp_state_e          dsp_q, dsp_d;
    cmd_t                cmd_q, cmd_d;

    logic [DATA_BIT-1:0] asm_out_pattern, asm_freq_pattern;
    cmd_t                asm_cmd, head_cmd;
    logic [$bits(cmd_t)-1:0] head_bits;
    logic                pkt_ok, fifo_wr, fifo_rd, fifo_full, fifo_empty;

    assign asm_out_pattern  = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
    assign asm_freq_pattern = {buf_q[7], buf_q[6], buf_q[5], buf_q[4]};

    always_comb begin
        asm_cmd.channel      = buf_q[BYTE_CTRL][CTRL_CH_MSB:CTRL_CH_LSB];
        asm_cmd.mode         = buf_q[BYTE_CTRL][CTRL_MODE_BIT];
        asm_cmd.out_pattern  = asm_out_pattern;
        asm_cmd.freq_pattern = asm_freq_pattern;
        asm_cmd.slow_period  = buf_q[BYTE_SLOW];
        asm_cmd.fast_period  = buf_q[BYTE_FAST];
    end

    // ---------------- packet assembler ----------------
    always_comb begin
        asm_d           = asm_q;
        byte_cnt_d      = byte_cnt_q;
        tmo_d           = tmo_q;
        buf_d           = buf_q;
        fifo_wr         = 1'b0;
        o_err_tick      = 1'b0;
        o_overflow_tick = 1'b0;
        pkt_ok          = pkt_is_valid(buf_q[BYTE_CTRL], buf_q[BYTE_SLOW], buf_q[BYTE_FAST]);

        case (asm_q)
            ASM_IDLE: begin
                if (i_rx_done_tick) begin
                    buf_d[0]   = i_data;
                    byte_cnt_d = CNT_W'(1);
                    tmo_d      = '0;
                    asm_d      = ASM_RECV;
                end
            end
            ASM_RECV: begin
                if (i_rx_done_tick) begin
                    buf_d[byte_cnt_q] = i_data;
                    tmo_d             = '0;
                    if (byte_cnt_q == LAST_IDX) begin
                        byte_cnt_d = '0;
                        asm_d      = ASM_CHECK;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    o_err_tick = 1'b1;
                    tmo_d      = '0;
                    byte_cnt_d = '0;
                    asm_d      = ASM_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ASM_CHECK: begin
                if (!pkt_ok) begin
                    o_err_tick = 1'b1;
                end else if (fifo_full && !fifo_rd) begin
                    o_overflow_tick = 1'b1;
                end else begin
                    fifo_wr = 1'b1;
                end
                // A tick here already belongs to the next packet; the buffer
                // slot it overwrites has been read combinationally above.
                if (i_rx_done_tick) begin
                    buf_d[0]   = i_data;
                    byte_cnt_d = CNT_W'(1);
                    tmo_d      = '0;
                    asm_d      = ASM_RECV;
                end else begin
                    asm_d = ASM_IDLE;
                end
            end
            default: asm_d = ASM_IDLE;
        endcase
    end

    // ---------------- command queue ----------------
    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (fifo_wr),
        .i_wr_data (asm_cmd),
        .i_rd_en   (fifo_rd),
        .o_rd_data (head_bits),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (o_fifo_count)
    );

    assign head_cmd = cmd_t'(head_bits);

    // ---------------- in-order dispatcher ----------------
    // The head is copied into cmd_q on entry to ISSUE so the presented fields
    // stay frozen regardless of later i_ch_busy changes.
    always_comb begin
        dsp_d   = dsp_q;
        cmd_d   = cmd_q;
        fifo_rd = 1'b0;
        case (dsp_q)
            DSP_IDLE: begin
                if (!fifo_empty && !i_ch_busy[head_cmd.channel]) begin
                    cmd_d = head_cmd;
                    dsp_d = DSP_ISSUE;
                end
            end
            DSP_ISSUE: begin
                if (cmd.i_cmd_ready) begin
                    fifo_rd = 1'b1;
                    dsp_d   = DSP_IDLE;
                end
            end
            default: dsp_d = DSP_IDLE;
        endcase
    end

    assign cmd.o_cmd_valid    = (dsp_q == DSP_ISSUE);
    assign cmd.o_channel      = cmd_q.channel;
    assign cmd.o_mode         = cmd_q.mode;
    assign cmd.o_out_pattern  = cmd_q.out_pattern;
    assign cmd.o_freq_pattern = cmd_q.freq_pattern;
    assign cmd.o_slow_period  = cmd_q.slow_period;
    assign cmd.o_fast_period  = cmd_q.fast_period;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            asm_q      <= ASM_IDLE;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            dsp_q      <= DSP_IDLE;
            cmd_q      <= '0;
        end else begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            dsp_q      <= dsp_d;
            cmd_q      <= cmd_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_serial_cmd_scheduler.sv
module tb_serial_cmd_scheduler;
    import serial_cmd_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_data;
    logic        tick;
    logic [15:0] busy;
    logic        err, ovf;
    logic [2:0]  cnt;

    serial_cmd_scheduler_if #(.DATA_BIT(32)) cmd_if ();

    serial_cmd_scheduler #(
        .DATA_BIT    (32),
        .PACK_NUM    (11),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CLK (2000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_data          (i_data),
        .i_rx_done_tick  (tick),
        .i_ch_busy       (busy),
        .cmd             (cmd_if),
        .o_err_tick      (err),
        .o_overflow_tick (ovf),
        .o_fifo_count    (cnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   err_cnt  = 0;
    int   ovf_cnt  = 0;
    cmd_t sb[$];

    typedef struct {
        logic [31:0] outp;
        logic [31:0] freqp;
        logic [7:0]  ctrl;
        logic [7:0]  slow;
        logic [7:0]  fast;
        bit          exp_ok;
        logic [3:0]  exp_ch;
        logic        exp_mode;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic [3:0] ch, input logic m,
                                    input logic [31:0] o, input logic [31:0] f,
                                    input logic [7:0] s, input logic [7:0] fa);
        cmd_t c;
        c.channel      = ch;
        c.mode         = m;
        c.out_pattern  = o;
        c.freq_pattern = f;
        c.slow_period  = s;
        c.fast_period  = fa;
        return c;
    endfunction

    function automatic cmd_t dut_cmd();
        return mk_cmd(cmd_if.o_channel, cmd_if.o_mode, cmd_if.o_out_pattern,
                      cmd_if.o_freq_pattern, cmd_if.o_slow_period, cmd_if.o_fast_period);
    endfunction

    // Scoreboard consumer plus hold-stability watch, sampled on the falling edge.
    task automatic monitor();
        logic hold;
        cmd_t last, got;
        hold = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                hold = 1'b0;
            end else begin
                got = dut_cmd();
                if (err) err_cnt++;
                if (ovf) ovf_cnt++;
                if (hold) begin
                    check("valid_held", 128'(cmd_if.o_cmd_valid), 128'(1));
                    check("fields_held", 128'(got), 128'(last));
                end
                if (cmd_if.o_cmd_valid && cmd_if.i_cmd_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd: got %0h expected no command", got);
                    end else begin
                        check("cmd_fields", 128'(got), 128'(sb.pop_front()));
                    end
                end
                hold = cmd_if.o_cmd_valid && !cmd_if.i_cmd_ready;
                last = got;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; the byte is sampled on the next edge.
    task automatic send_byte(input logic [7:0] b);
        i_data = b;
        tick   = 1'b1;
        @(posedge clk);
        #1;
        tick   = 1'b0;
    endtask

    task automatic send_bytes(input logic [31:0] o, input logic [31:0] f,
                              input logic [7:0] c, input logic [7:0] s,
                              input logic [7:0] fa, input int nbytes);
        logic [7:0] pkt [11];
        for (int i = 0; i < 4; i++) begin
            pkt[i]     = o[8*i +: 8];
            pkt[i + 4] = f[8*i +: 8];
        end
        pkt[8]  = c;
        pkt[9]  = s;
        pkt[10] = fa;
        for (int i = 0; i < nbytes; i++) send_byte(pkt[i]);
    endtask

    task automatic send_packet(input logic [31:0] o, input logic [31:0] f,
                               input logic [7:0] c, input logic [7:0] s, input logic [7:0] fa);
        send_bytes(o, f, c, s, fa, 11);
    endtask

    initial begin
        int e0, o0, viol;

        vecs[0] = '{32'hDEADBEEF, 32'h12345678, 8'h31, 8'h0A, 8'h02, 1'b1, 4'd3,  1'b0, "ch3_oneshot"};
        vecs[1] = '{32'h0F0F0F0F, 32'hFFFFFFFF, 8'hF5, 8'hFF, 8'h01, 1'b1, 4'd15, 1'b1, "ch15_repeat"};
        vecs[2] = '{32'h55555555, 32'h00000000, 8'h09, 8'h14, 8'h05, 1'b0, 4'd0,  1'b0, "reserved_set"};
        vecs[3] = '{32'h55555555, 32'h00000000, 8'h01, 8'h00, 8'h05, 1'b0, 4'd0,  1'b0, "slow_zero"};
        vecs[4] = '{32'h55555555, 32'h00000000, 8'h01, 8'h14, 8'h00, 1'b0, 4'd0,  1'b0, "fast_zero"};
        vecs[5] = '{32'h55555555, 32'h00000000, 8'h02, 8'h14, 8'h05, 1'b0, 4'd0,  1'b0, "bad_opcode"};
        vecs[6] = '{32'h01020304, 32'hA0B0C0D0, 8'h85, 8'h01, 8'h80, 1'b1, 4'd8,  1'b1, "ch8_repeat"};

        rst_n  = 1'b1;
        tick   = 1'b0;
        i_data = 8'h00;
        busy   = 16'h0000;
        cmd_if.i_cmd_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(cmd_if.o_cmd_valid), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_count", 128'(cnt), 128'(0));
        check("rst_data", 128'(dut_cmd()), 128'(0));
        rst_n = 1'b0;
        wait_cycles(2);
        check("post_rst_valid", 128'(cmd_if.o_cmd_valid), 128'(0));
        check("post_rst_count", 128'(cnt), 128'(0));

        // Basic packet with latency profile: valid appears 2 cycles after CHECK.
        e0 = err_cnt;
        sb.push_back(mk_cmd(4'd0, 1'b0, 32'h55555555, 32'h0, 8'h14, 8'h05));
        send_packet(32'h55555555, 32'h0, 8'h01, 8'h14, 8'h05);
        check("lat_check_cycle", 128'(cmd_if.o_cmd_valid), 128'(0));
        wait_cycles(1);
        check("lat_n2", 128'(cmd_if.o_cmd_valid), 128'(0));
        wait_cycles(1);
        check("lat_n3", 128'(cmd_if.o_cmd_valid), 128'(1));
        wait_cycles(3);
        check("basic_delivered", 128'(sb.size()), 128'(0));
        check("basic_no_err", 128'(err_cnt - e0), 128'(0));

        // Table of single packets, ready high, all channels idle.
        for (int i = 0; i < 7; i++) begin
            e0 = err_cnt;
            if (vecs[i].exp_ok)
                sb.push_back(mk_cmd(vecs[i].exp_ch, vecs[i].exp_mode, vecs[i].outp,
                                    vecs[i].freqp, vecs[i].slow, vecs[i].fast));
            send_packet(vecs[i].outp, vecs[i].freqp, vecs[i].ctrl, vecs[i].slow, vecs[i].fast);
            wait_cycles(6);
            check({vecs[i].name, "_err"}, 128'(err_cnt - e0), 128'(vecs[i].exp_ok ? 0 : 1));
            check({vecs[i].name, "_sb"}, 128'(sb.size()), 128'(0));
            check({vecs[i].name, "_count"}, 128'(cnt), 128'(0));
        end

        // Busy channel blocks dispatch for 500 clocks.
        busy = 16'h0001;
        sb.push_back(mk_cmd(4'd0, 1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 8'h14, 8'h05));
        send_packet(32'hA5A5A5A5, 32'h3C3C3C3C, 8'h05, 8'h14, 8'h05);
        viol = 0;
        repeat (500) begin
            if (cmd_if.o_cmd_valid) viol++;
            wait_cycles(1);
        end
        check("busy_block_valid", 128'(viol), 128'(0));
        check("busy_block_count", 128'(cnt), 128'(1));
        busy = 16'h0000;
        wait_cycles(6);
        check("busy_release_sb", 128'(sb.size()), 128'(0));

        // Valid is not withdrawn when busy rises during ISSUE.
        cmd_if.i_cmd_ready = 1'b0;
        sb.push_back(mk_cmd(4'd0, 1'b0, 32'h11223344, 32'h55667788, 8'h02, 8'h03));
        send_packet(32'h11223344, 32'h55667788, 8'h01, 8'h02, 8'h03);
        wait_cycles(4);
        check("issue_valid", 128'(cmd_if.o_cmd_valid), 128'(1));
        busy = 16'h0001;
        wait_cycles(5);
        check("busy_rise_keep_valid", 128'(cmd_if.o_cmd_valid), 128'(1));
        cmd_if.i_cmd_ready = 1'b1;
        wait_cycles(2);
        busy = 16'h0000;
        wait_cycles(2);
        check("busy_rise_sb", 128'(sb.size()), 128'(0));

        // Six packets with ready low: four queued, two overflow.
        cmd_if.i_cmd_ready = 1'b0;
        o0 = ovf_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k < 4)
                sb.push_back(mk_cmd(4'(k + 1), 1'b0, 32'h10000000 + 32'(k), 32'hF0000000 + 32'(k), 8'h0A, 8'h02));
            send_packet(32'h10000000 + 32'(k), 32'hF0000000 + 32'(k), {4'(k + 1), 4'b0001}, 8'h0A, 8'h02);
        end
        wait_cycles(3);
        check("ovf_count_full", 128'(cnt), 128'(4));
        check("ovf_ticks", 128'(ovf_cnt - o0), 128'(2));
        cmd_if.i_cmd_ready = 1'b1;
        wait_cycles(20);
        check("ovf_drain_sb", 128'(sb.size()), 128'(0));
        check("ovf_drain_count", 128'(cnt), 128'(0));

        // Queue full but a pop lands in the CHECK cycle: write accepted.
        cmd_if.i_cmd_ready = 1'b0;
        o0 = ovf_cnt;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(mk_cmd(4'd2, 1'b1, 32'h20000000 + 32'(k), 32'h0, 8'h07, 8'h09));
            if (k < 4) send_packet(32'h20000000 + 32'(k), 32'h0, 8'h25, 8'h07, 8'h09);
        end
        wait_cycles(3);
        check("fullpop_pre_count", 128'(cnt), 128'(4));
        send_bytes(32'h20000004, 32'h0, 8'h25, 8'h07, 8'h09, 10);
        send_byte(8'h09);
        cmd_if.i_cmd_ready = 1'b1;
        wait_cycles(1);
        cmd_if.i_cmd_ready = 1'b0;
        check("fullpop_count", 128'(cnt), 128'(4));
        check("fullpop_no_ovf", 128'(ovf_cnt - o0), 128'(0));
        cmd_if.i_cmd_ready = 1'b1;
        wait_cycles(20);
        check("fullpop_sb", 128'(sb.size()), 128'(0));

        // Back-to-back packets: the second packet's first byte arrives in CHECK.
        e0 = err_cnt;
        sb.push_back(mk_cmd(4'd4, 1'b0, 32'hCAFEF00D, 32'h0BADBEEF, 8'h33, 8'h44));
        sb.push_back(mk_cmd(4'd5, 1'b1, 32'h76543210, 32'hFEDCBA98, 8'h55, 8'h66));
        send_packet(32'hCAFEF00D, 32'h0BADBEEF, 8'h41, 8'h33, 8'h44);
        send_packet(32'h76543210, 32'hFEDCBA98, 8'h55, 8'h55, 8'h66);
        wait_cycles(10);
        check("b2b_sb", 128'(sb.size()), 128'(0));
        check("b2b_no_err", 128'(err_cnt - e0), 128'(0));

        // Inter-byte timeout discards a partial packet.
        e0 = err_cnt;
        send_bytes(32'h99999999, 32'h0, 8'h01, 8'h01, 8'h01, 5);
        wait_cycles(2100);
        check("timeout_err", 128'(err_cnt - e0), 128'(1));
        check("timeout_count", 128'(cnt), 128'(0));
        sb.push_back(mk_cmd(4'd6, 1'b0, 32'h13579BDF, 32'h2468ACE0, 8'h10, 8'h20));
        send_packet(32'h13579BDF, 32'h2468ACE0, 8'h61, 8'h10, 8'h20);
        wait_cycles(6);
        check("timeout_next_sb", 128'(sb.size()), 128'(0));
        check("timeout_next_err", 128'(err_cnt - e0), 128'(1));

        // Reset mid-packet with two commands queued.
        cmd_if.i_cmd_ready = 1'b0;
        send_packet(32'hAAAA0001, 32'h0, 8'h71, 8'h01, 8'h02);
        send_packet(32'hAAAA0002, 32'h0, 8'h71, 8'h01, 8'h02);
        send_bytes(32'hAAAA0003, 32'h0, 8'h71, 8'h01, 8'h02, 8);
        check("prereset_count", 128'(cnt), 128'(2));
        rst_n = 1'b1;
        wait_cycles(2);
        check("inreset_count", 128'(cnt), 128'(0));
        check("inreset_valid", 128'(cmd_if.o_cmd_valid), 128'(0));
        check("inreset_data", 128'(dut_cmd()), 128'(0));
        rst_n = 1'b0;
        wait_cycles(2);
        check("postreset_count", 128'(cnt), 128'(0));
        check("postreset_valid", 128'(cmd_if.o_cmd_valid), 128'(0));
        cmd_if.i_cmd_ready = 1'b1;
        e0 = err_cnt;
        sb.push_back(mk_cmd(4'd9, 1'b1, 32'h0BEEF000, 32'h000CAFE0, 8'h21, 8'h12));
        send_packet(32'h0BEEF000, 32'h000CAFE0, 8'h95, 8'h21, 8'h12);
        wait_cycles(6);
        check("postreset_sb", 128'(sb.size()), 128'(0));
        check("postreset_no_err", 128'(err_cnt - e0), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
